// File: rtl/vertex_deserializer.sv
// Collects NSLOT serial coordinate words into a shadow frame and publishes the
// full frame on out_data. The next frame is collected while the previous one waits.
module vertex_deserializer #(
  parameter int WIDTH  = 10,
  parameter int NVERT  = 3,
  parameter int NCOORD = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NVERT*NCOORD*WIDTH-1:0]   out_data,
  output logic                            busy,
  output logic                            restart_err
);

  localparam int NSLOT   = NVERT * NCOORD;
  localparam int IDX_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int FRAME_W = NSLOT * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic [FRAME_W-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 restart_err_q, restart_err_d;
  logic                 last_stall;
  logic                 accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      restart_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      restart_err_q <= restart_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    restart_err_d = 1'b0;

    // The final word may only land once the output register is free to take it.
    last_stall = (idx_q == LAST_IDX) && out_valid_q && !out_ready;
    in_ready   = (state_q == COLLECT) && !abort && !start && !last_stall;
    accept     = in_valid && in_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start && !abort) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (start) begin
          idx_d         = '0;
          restart_err_d = 1'b1;
        end else if (accept) begin
          shadow_d[int'(idx_q)*WIDTH +: WIDTH] = in_data;
          if (idx_q == LAST_IDX) begin
            // Final word bypasses the shadow straight into the published frame.
            out_data_d                            = shadow_q;
            out_data_d[(NSLOT-1)*WIDTH +: WIDTH]  = in_data;
            out_valid_d                           = 1'b1;
            state_d                               = IDLE;
            idx_d                                 = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = (state_q == COLLECT);
  assign restart_err = restart_err_q;

endmodule
